// File: rtl/mu0_bus_responder.sv
// mu0_bus_responder
//   Memory-mapped I/O target on the MU0 word bus. It claims four consecutive
//   word addresses starting at BASE_ADDR. The top level selects this block's
//   Din whenever `hit` is high, and otherwise selects MU0_Memory's Din.
//
//   Register map (offset = Addr[1:0]):
//     0 TXDATA  write: push Dout into the TX FIFO   read: 16'h0000
//     1 STATUS  read : {11'b0, ovf, rx_full, tx_full, tx_empty, 1'b0}
//               write: Dout[4]=1 clears the sticky ovf flag
//     2 RXDATA  read : held RX word (no side effect)
//     3 RXACK   write: release the RX holding register  read: 16'h0000
//
// Ports
//   Clk, Reset        clock; synchronous active-low reset
//   Addr, Dout, Wr    MU0 bus address, write data and write strobe
//   Din, hit          read data and window-select (both combinational)
//   tx_data/valid/ready  TX FIFO head towards an external consumer
//   rx_data/valid/ready  external producer into the RX holding register
module mu0_bus_responder #(
  parameter logic [11:0] BASE_ADDR  = 12'hFF0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Addr,
  input  logic [15:0] Dout,
  input  logic        Wr,
  output logic [15:0] Din,
  output logic        hit,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_RXACK  = 2'd3;

  // TX FIFO state
  logic [15:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // RX and status state
  logic [15:0] rx_reg;
  logic        rx_full;
  logic        ovf;

  // Bus decode
  logic [1:0] offset;
  logic       bus_wr;
  logic       push_req;
  logic       ovf_clr;
  logic       rx_ack;

  // FIFO control
  logic tx_full;
  logic tx_empty;
  logic pop;
  logic push_ok;
  logic overflow;
  logic capture;

  assign hit      = (Addr[11:2] == BASE_ADDR[11:2]);
  assign offset   = Addr[1:0];
  assign bus_wr   = hit & Wr;
  assign push_req = bus_wr & (offset == OFF_TXDATA);
  assign ovf_clr  = bus_wr & (offset == OFF_STATUS) & Dout[4];
  assign rx_ack   = bus_wr & (offset == OFF_RXACK);

  assign tx_full  = (count == FULL_COUNT);
  assign tx_empty = (count == '0);
  assign tx_valid = ~tx_empty;
  assign tx_data  = mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;

  // A pop in the same cycle frees the slot a push into a full FIFO needs;
  // with a full FIFO wr_ptr == rd_ptr, so the head is read out before the
  // overwrite lands on the same edge.
  assign push_ok  = push_req & (~tx_full | pop);
  assign overflow = push_req & tx_full & ~pop;

  assign rx_ready = ~rx_full;
  assign capture  = rx_valid & rx_ready;

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count <= count - CNT_W'(1);
      end
      // A coincident overflow beats a software clear.
      if (overflow) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // FIFO storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (Reset && push_ok) begin
      mem[wr_ptr] <= Dout;
    end
  end

  // RX holding register: capture only while empty, ack only matters while full
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rx_full <= 1'b0;
      rx_reg  <= '0;
    end else if (capture) begin
      rx_full <= 1'b1;
      rx_reg  <= rx_data;
    end else if (rx_ack) begin
      rx_full <= 1'b0;
    end
  end

  // Read mux; MU0 has no read strobe, so reads never change state.
  always_comb begin
    Din = '0;
    if (hit) begin
      case (offset)
        OFF_STATUS: Din = {11'b0, ovf, rx_full, tx_full, tx_empty, 1'b0};
        OFF_RXDATA: Din = rx_reg;
        default:    Din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_bus_responder.sv
// Testbench for mu0_bus_responder: directed scenarios followed by randomized
// bus/handshake traffic, all checked against a queue-based reference model.
module tb_mu0_bus_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [11:0] Addr;
  logic [15:0] Dout;
  logic        Wr;
  logic [15:0] Din;
  logic        hit;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  always #5 Clk = ~Clk;

  mu0_bus_responder #(
    .BASE_ADDR (12'hFF0),
    .FIFO_DEPTH(4)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Addr    (Addr),
    .Dout    (Dout),
    .Wr      (Wr),
    .Din     (Din),
    .hit     (hit),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
  );

  // Reference model state
  localparam int DEPTH = 4;
  logic [15:0] q[$];
  bit          m_ovf;
  bit          m_rxfull;
  logic [15:0] m_rxword;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [11:0] a);
    return (a >= 12'hFF0) && (a <= 12'hFF3);
  endfunction

  function automatic logic [15:0] m_din();
    logic [15:0] r;
    r = 16'h0000;
    if (m_hit(Addr)) begin
      if (Addr == 12'hFF1) begin
        r = 16'h0000;
        if (q.size() == 0)     r = r + 16'd2;
        if (q.size() == DEPTH) r = r + 16'd4;
        if (m_rxfull)          r = r + 16'd8;
        if (m_ovf)             r = r + 16'd16;
      end else if (Addr == 12'hFF2) begin
        r = m_rxword;
      end
    end
    return r;
  endfunction

  task automatic check_outputs();
    chk("hit", {15'b0, hit}, {15'b0, m_hit(Addr)});
    chk("din", Din, m_din());
    chk("tx_valid", {15'b0, tx_valid}, {15'b0, q.size() > 0});
    if (q.size() > 0) chk("tx_data", tx_data, q[0]);
    chk("rx_ready", {15'b0, rx_ready}, {15'b0, !m_rxfull});
  endtask

  // Apply the rules of one rising edge to the model, using current inputs.
  task automatic model_edge();
    bit          was_full;
    bit          popped;
    bit          pushing;
    bit          ovf_set;
    logic [15:0] junk;
    if (!Reset) begin
      q.delete();
      m_ovf    = 0;
      m_rxfull = 0;
      m_rxword = 16'h0000;
    end else begin
      was_full = (q.size() == DEPTH);
      popped   = (q.size() > 0) && tx_ready;
      pushing  = Wr && (Addr == 12'hFF0);
      ovf_set  = 0;
      if (popped) junk = q.pop_front();
      if (pushing) begin
        if (!was_full || popped) q.push_back(Dout);
        else ovf_set = 1;
      end
      if (ovf_set) m_ovf = 1;
      else if (Wr && Addr == 12'hFF1 && Dout[4]) m_ovf = 0;
      if (rx_valid && !m_rxfull) begin
        m_rxfull = 1;
        m_rxword = rx_data;
      end else if (Wr && Addr == 12'hFF3) begin
        m_rxfull = 0;
      end
    end
  endtask

  // Called just after a falling edge with inputs already set.
  task automatic cycle(input bit do_check);
    #1;
    if (do_check) check_outputs();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
  endtask

  task automatic bus(input logic [11:0] a, input logic w, input logic [15:0] d);
    Addr = a;
    Wr   = w;
    Dout = d;
    cycle(1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(12'h000, 1'b0, 16'h0000);
  endtask

  initial begin
    Reset    = 1'b0;
    Addr     = 12'h000;
    Dout     = 16'h0000;
    Wr       = 1'b0;
    tx_ready = 1'b0;
    rx_data  = 16'h0000;
    rx_valid = 1'b0;
    @(negedge Clk);

    // Reset, then status
    cycle(0);
    Reset = 1'b1;
    Addr  = 12'hFF1;
    #1;
    chk("rst_status", Din, 16'h0002);
    chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst_rx_ready", {15'b0, rx_ready}, 16'h0001);
    cycle(1);

    // Two writes, then drain in order
    tx_ready = 1'b0;
    bus(12'hFF0, 1'b1, 16'hA5A5);
    #1;
    chk("first_valid", {15'b0, tx_valid}, 16'h0001);
    chk("first_data", tx_data, 16'hA5A5);
    bus(12'hFF0, 1'b1, 16'h1234);
    tx_ready = 1'b1;
    #1;
    chk("head_a5a5", tx_data, 16'hA5A5);
    idle(1);
    #1;
    chk("head_1234", tx_data, 16'h1234);
    idle(1);
    #1;
    chk("drained", {15'b0, tx_valid}, 16'h0000);

    // Overflow on fifth write, drain, clear ovf
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus(12'hFF0, 1'b1, 16'(i));
    Addr = 12'hFF1;
    Wr   = 1'b0;
    #1;
    chk("ovf_status", Din, 16'h0014);
    cycle(1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      Addr = 12'h000;
      #1;
      chk("drain_word", tx_data, 16'(i));
      cycle(1);
    end
    tx_ready = 1'b0;
    bus(12'hFF1, 1'b1, 16'h0010);
    Addr = 12'hFF1;
    #1;
    chk("ovf_cleared", Din, 16'h0002);
    cycle(1);

    // Push into full FIFO with simultaneous pop, then wraparound traffic
    for (int i = 0; i < 4; i++) bus(12'hFF0, 1'b1, 16'h0100 + 16'(i));
    tx_ready = 1'b1;
    bus(12'hFF0, 1'b1, 16'h0006);
    Addr = 12'hFF1;
    Wr   = 1'b0;
    tx_ready = 1'b0;
    #1;
    chk("full_no_ovf", Din, 16'h0004);
    cycle(1);
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) bus(12'hFF0, ($urandom_range(0, 3) != 0), 16'h0200 + 16'(i));
    idle(6);

    // RX path
    rx_data  = 16'hBEEF;
    rx_valid = 1'b1;
    idle(1);
    rx_data = 16'hCAFE;
    Addr    = 12'hFF2;
    #1;
    chk("rx_ready_low", {15'b0, rx_ready}, 16'h0000);
    chk("rx_beef", Din, 16'hBEEF);
    cycle(1);
    bus(12'hFF2, 1'b0, 16'h0000);
    bus(12'hFF3, 1'b1, 16'h0000);
    #1;
    chk("rx_ready_back", {15'b0, rx_ready}, 16'h0001);
    cycle(1);
    rx_valid = 1'b0;
    Addr     = 12'hFF2;
    Wr       = 1'b0;
    #1;
    chk("rx_cafe", Din, 16'hCAFE);
    cycle(1);

    // Reset with queued TX data and full RX register
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus(12'hFF0, 1'b1, 16'h0300 + 16'(i));
    Reset = 1'b0;
    bus(12'hFF0, 1'b1, 16'h0399);
    Reset = 1'b1;
    Addr  = 12'hFF2;
    Wr    = 1'b0;
    #1;
    chk("rst2_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst2_rx_ready", {15'b0, rx_ready}, 16'h0001);
    chk("rst2_rxdata", Din, 16'h0000);
    cycle(1);
    Addr = 12'hFEF;
    #1;
    chk("miss_hit", {15'b0, hit}, 16'h0000);
    chk("miss_din", Din, 16'h0000);
    cycle(1);

    // Randomized traffic with varying consumer/producer pressure
    for (int blk = 0; blk < 16; blk++) begin
      int ready_pct;
      ready_pct = $urandom_range(0, 100);
      for (int i = 0; i < 200; i++) begin
        Reset    = ($urandom_range(0, 149) != 0);
        Addr     = ($urandom_range(0, 7) == 0) ? 12'($urandom) : {10'h3FC, 2'($urandom)};
        Wr       = ($urandom_range(0, 1) == 1);
        Dout     = 16'($urandom);
        tx_ready = ($urandom_range(0, 99) < ready_pct);
        rx_valid = ($urandom_range(0, 1) == 1);
        rx_data  = 16'($urandom);
        cycle(1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
